// File: rtl/apb_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apb_arb_pkg
//  Description : Shared state encoding and default widths for the APB
//                round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_arb_pkg;

    localparam int STATE_W     = 2;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage : apb_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Searches ptr+1, ptr+2, ...
//                with wrap and reports the first requester found.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // One extra bit so ptr + N never overflows before the wrap subtraction.
    logic [IW:0] w_cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_cand     = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = {1'b0, ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!any && req[w_cand[IW-1:0]]) begin
                any                         = 1'b1;
                gnt_idx                     = w_cand[IW-1:0];
                gnt_onehot[w_cand[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_arbiter
//  Description : Shares one APB master port between NUM_REQ requesters with
//                round-robin arbitration and a wait-state watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ-1:0]        write_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i
);

    localparam int              IW       = $clog2(NUM_REQ);
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   PTR_RST  = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t          r_state;
    logic [IW-1:0]       r_ptr;
    logic [CW-1:0]       r_cnt;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_write;
    logic [DATA_W-1:0]   w_wdata;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req        (req_i),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt),
        .gnt_idx    (w_idx),
        .any        (w_any)
    );

    // One-hot payload select; only the winner's slice reaches the APB outputs.
    always_comb begin
        w_addr  = '0;
        w_write = 1'b0;
        w_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_addr  = addr_i[k*ADDR_W +: ADDR_W];
                w_write = write_i[k];
                w_wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // The APB output registers double as the payload latch for the transfer.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_ptr     <= PTR_RST;
            r_cnt     <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state   <= SETUP;
                        r_ptr     <= w_idx;
                        r_cnt     <= '0;
                        gnt_o     <= w_gnt;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        paddr_o   <= w_addr;
                        pwrite_o  <= w_write;
                        pwdata_o  <= w_wdata;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i) begin
                        r_state   <= DONE;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        done_o    <= gnt_o;
                        err_o     <= 1'b0;
                        rdata_o   <= pwrite_o ? '0 : prdata_i;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= DONE;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        done_o    <= gnt_o;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    gnt_o    <= '0;
                    done_o   <= '0;
                    err_o    <= 1'b0;
                    rdata_o  <= '0;
                    paddr_o  <= '0;
                    pwrite_o <= 1'b0;
                    pwdata_o <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : apb_rr_arbiter
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_rr_arbiter
//  Description : Self-checking bench for apb_rr_arbiter with a scripted APB
//                slave and a round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      pclk = 1'b0;
    logic                      preset;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ-1:0]        write_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic                      err_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [ADDR_W-1:0]         paddr_o;
    logic                      pwrite_o;
    logic [DATA_W-1:0]         pwdata_o;
    logic [DATA_W-1:0]         prdata_i;
    logic                      pready_i;

    int          vectors     = 0;
    int          miscompares = 0;
    int          slave_waits = 0;
    bit          slave_hang  = 0;
    logic [31:0] slave_rdata = '0;
    int          acc_cnt     = 0;
    int          mptr        = NUM_REQ - 1;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .write_i   (write_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .paddr_o   (paddr_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i)
    );

    always #5 pclk = ~pclk;

    // Advance one clock; the slave answers after slave_waits wait states.
    task automatic tick();
        @(posedge pclk);
        #1;
        if (psel_o && penable_o) acc_cnt++;
        else acc_cnt = 0;
        pready_i = psel_o && penable_o && !slave_hang && (acc_cnt > slave_waits);
        prdata_i = pready_i ? slave_rdata : DATA_W'($urandom);
    endtask

    // Round-robin rule: first pending requester after ptr, with wrap.
    function automatic int rr_pick(logic [NUM_REQ-1:0] req, int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_slot(int k, logic [31:0] a, bit w, logic [31:0] d);
        addr_i[k*ADDR_W +: ADDR_W]  = a;
        write_i[k]                  = w;
        wdata_i[k*DATA_W +: DATA_W] = d;
    endtask

    // Runs until done_o pulses (bounded); reports ACCESS length and payload stability.
    task automatic wait_done(output bit got, output int pen, output bit stable);
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              w0;
        bit                first;
        got = 0; pen = 0; stable = 1; first = 1;
        a0 = '0; d0 = '0; w0 = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (psel_o) begin
                if (first) begin
                    a0 = paddr_o; d0 = pwdata_o; w0 = pwrite_o; first = 0;
                end else if ({paddr_o, pwdata_o, pwrite_o} !== {a0, d0, w0}) begin
                    stable = 0;
                end
            end
            tick();
            if (penable_o) pen++;
            if (done_o != '0) got = 1;
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick(); tick();
        vectors++;
        if ({gnt_o, done_o, err_o, rdata_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b done=%b psel=%b paddr=%h got nonzero, expected all 0", gnt_o, done_o, psel_o, paddr_o);
        end
        #2 preset = 1'b0;
        tick();
        vectors++;
        if ({gnt_o, psel_o, penable_o} !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: gnt=%b psel=%b penable=%b expected 0", gnt_o, psel_o, penable_o);
        end
        mptr = NUM_REQ - 1;
    endtask

    task automatic test_single_read();
        set_slot(0, 32'h10, 1'b0, 32'h0);
        slave_waits = 0; slave_rdata = 32'h5;
        req_i = 4'b0001;
        tick();
        vectors++;
        if ({psel_o, penable_o, gnt_o, paddr_o, pwrite_o} !== {1'b1, 1'b0, 4'b0001, 32'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL read_setup: psel=%b penable=%b gnt=%b paddr=%h expected 1 0 0001 00000010", psel_o, penable_o, gnt_o, paddr_o);
        end
        tick();
        vectors++;
        if ({psel_o, penable_o, done_o} !== {1'b1, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL read_access: psel=%b penable=%b done=%b expected 1 1 0000", psel_o, penable_o, done_o);
        end
        tick();
        vectors++;
        if ({done_o, rdata_o, err_o, gnt_o, psel_o, penable_o} !== {4'b0001, 32'h5, 1'b0, 4'b0001, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL read_done: done=%b rdata=%h err=%b gnt=%b psel=%b expected 0001 00000005 0 0001 0", done_o, rdata_o, err_o, gnt_o, psel_o);
        end
        req_i = '0;
        tick();
        vectors++;
        if ({gnt_o, done_o, err_o, rdata_o, psel_o, paddr_o} !== '0) begin
            miscompares++;
            $display("FAIL read_return_idle: gnt=%b done=%b rdata=%h paddr=%h expected 0", gnt_o, done_o, rdata_o, paddr_o);
        end
        mptr = 0;
    endtask

    task automatic test_write_wait();
        bit got, stable;
        int pen;
        set_slot(2, 32'h20, 1'b1, 32'hA5);
        slave_waits = 2; slave_rdata = 32'hDEAD_BEEF;
        req_i = 4'b0100;
        tick();
        vectors++;
        if ({gnt_o, pwrite_o, pwdata_o} !== {4'b0100, 1'b1, 32'hA5}) begin
            miscompares++;
            $display("FAIL write_setup: gnt=%b pwrite=%b pwdata=%h expected 0100 1 000000a5", gnt_o, pwrite_o, pwdata_o);
        end
        wait_done(got, pen, stable);
        vectors++;
        if ({got, pen, stable} !== {1'b1, 32'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL write_access: done_seen=%b penable_cycles=%0d stable=%b expected 1 3 1", got, pen, stable);
        end
        vectors++;
        if ({done_o, err_o, rdata_o} !== {4'b0100, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL write_done: done=%b err=%b rdata=%h expected 0100 0 0", done_o, err_o, rdata_o);
        end
        req_i = '0;
        tick();
        mptr = 2;
    endtask

    task automatic test_all_four();
        bit got, stable;
        int pen, exp;
        logic [31:0] rd;
        preset = 1'b1; tick(); #2 preset = 1'b0;
        mptr = NUM_REQ - 1;
        for (int k = 0; k < NUM_REQ; k++) set_slot(k, 32'h100 + 32'(k), 1'b0, 32'h0);
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = rr_pick(req_i, mptr);
            rd = $urandom;
            slave_waits = $urandom_range(0, 2); slave_rdata = rd;
            if (i > 0) tick();
            tick();
            vectors++;
            if (gnt_o !== 4'(1 << exp)) begin
                miscompares++;
                $display("FAIL all4_grant%0d: gnt=%b expected %b", i, gnt_o, 4'(1 << exp));
            end
            wait_done(got, pen, stable);
            vectors++;
            if (!got || done_o !== 4'(1 << exp) || !$onehot(done_o) || rdata_o !== rd) begin
                miscompares++;
                $display("FAIL all4_done%0d: done=%b rdata=%h expected %b %h", i, done_o, rdata_o, 4'(1 << exp), rd);
            end
            mptr = exp;
        end
        vectors++;
        if (mptr !== 0) begin
            miscompares++;
            $display("FAIL all4_order: last grant=%0d expected 0", mptr);
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit got, stable;
        int pen;
        logic [31:0] rd;
        set_slot(1, 32'h30, 1'b0, 32'h0);
        set_slot(2, 32'h34, 1'b0, 32'h0);
        slave_hang = 1; slave_rdata = 32'h1234_5678;
        req_i = 4'b0110;
        tick();
        vectors++;
        if (gnt_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_grant: gnt=%b expected 0010", gnt_o);
        end
        wait_done(got, pen, stable);
        vectors++;
        if ({got, pen, done_o, err_o, rdata_o} !== {1'b1, 32'd16, 4'b0010, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_done: seen=%b penable_cycles=%0d done=%b err=%b rdata=%h expected 1 16 0010 1 0", got, pen, done_o, err_o, rdata_o);
        end
        slave_hang = 0; slave_waits = 0;
        rd = $urandom; slave_rdata = rd;
        req_i = 4'b0100;
        tick(); tick();
        vectors++;
        if (gnt_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL timeout_next_grant: gnt=%b expected 0100", gnt_o);
        end
        wait_done(got, pen, stable);
        vectors++;
        if ({got, done_o, err_o, rdata_o} !== {1'b1, 4'b0100, 1'b0, rd}) begin
            miscompares++;
            $display("FAIL timeout_next_done: done=%b err=%b rdata=%h expected 0100 0 %h", done_o, err_o, rdata_o, rd);
        end
        req_i = '0;
        tick();
        mptr = 2;
    endtask

    task automatic test_reset_mid();
        bit got, stable, saw_done;
        int pen;
        set_slot(3, 32'h40, 1'b1, 32'h77);
        set_slot(0, 32'h44, 1'b0, 32'h0);
        slave_waits = 5;
        req_i = 4'b1000;
        tick(); tick();
        vectors++;
        if ({psel_o, penable_o, gnt_o} !== {1'b1, 1'b1, 4'b1000}) begin
            miscompares++;
            $display("FAIL rstmid_access: psel=%b penable=%b gnt=%b expected 1 1 1000", psel_o, penable_o, gnt_o);
        end
        #2 preset = 1'b1;
        #1;
        vectors++;
        if ({psel_o, penable_o, gnt_o, done_o, err_o} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: psel=%b penable=%b gnt=%b done=%b expected 0", psel_o, penable_o, gnt_o, done_o);
        end
        saw_done = 0;
        tick(); if (done_o != '0) saw_done = 1;
        #2 preset = 1'b0;
        slave_waits = 0;
        req_i = 4'b1001;
        tick(); if (done_o != '0) saw_done = 1;
        vectors++;
        if ({saw_done, gnt_o} !== {1'b0, 4'b0001}) begin
            miscompares++;
            $display("FAIL rstmid_priority: spurious_done=%b gnt=%b expected 0 0001", saw_done, gnt_o);
        end
        wait_done(got, pen, stable);
        vectors++;
        if ({got, done_o} !== {1'b1, 4'b0001}) begin
            miscompares++;
            $display("FAIL rstmid_done: done=%b expected 0001", done_o);
        end
        req_i = '0;
        tick();
        mptr = 0;
    endtask

    task automatic test_drop_req();
        bit got, stable;
        int pen;
        set_slot(1, 32'h50, 1'b0, 32'h0);
        slave_waits = 1;
        req_i = 4'b0010;
        tick();
        tick();
        req_i = 4'b0000;
        wait_done(got, pen, stable);
        vectors++;
        if ({got, done_o} !== {1'b1, 4'b0010}) begin
            miscompares++;
            $display("FAIL drop_done: seen=%b done=%b expected 1 0010", got, done_o);
        end
        req_i = 4'b1101;
        tick(); tick();
        vectors++;
        if (gnt_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL drop_next: gnt=%b expected 0100", gnt_o);
        end
        wait_done(got, pen, stable);
        req_i = '0;
        tick();
        mptr = 2;
    endtask

    task automatic test_random();
        bit got, stable, hang;
        int pen, exp, waits;
        logic [NUM_REQ-1:0] pending, fresh;
        logic [31:0] rd, exp_rd;
        pending = '0;
        for (int n = 0; n < 40; n++) begin
            fresh = (pending == '0) ? 4'($urandom_range(1, 15)) : 4'($urandom & $urandom);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (fresh[k] && !pending[k]) set_slot(k, $urandom, 1'($urandom), $urandom);
            end
            pending = pending | fresh;
            req_i = pending;
            hang = ($urandom_range(0, 7) == 0);
            waits = $urandom_range(0, 3);
            rd = $urandom;
            slave_hang = hang; slave_waits = waits; slave_rdata = rd;
            exp = rr_pick(pending, mptr);
            exp_rd = (hang || write_i[exp]) ? 32'h0 : rd;
            if (n > 0) tick();
            tick();
            vectors++;
            if ({gnt_o, paddr_o, pwrite_o, pwdata_o} !==
                {4'(1 << exp), addr_i[exp*ADDR_W +: ADDR_W], write_i[exp], wdata_i[exp*DATA_W +: DATA_W]}) begin
                miscompares++;
                $display("FAIL rand%0d_setup: gnt=%b paddr=%h pwrite=%b pwdata=%h expected gnt %b for requester %0d", n, gnt_o, paddr_o, pwrite_o, pwdata_o, 4'(1 << exp), exp);
            end
            wait_done(got, pen, stable);
            vectors++;
            if ({got, stable, done_o, err_o, rdata_o, pen} !==
                {1'b1, 1'b1, 4'(1 << exp), hang, exp_rd, (hang ? 32'd16 : 32'(waits + 1))}) begin
                miscompares++;
                $display("FAIL rand%0d_done: seen=%b stable=%b done=%b err=%b rdata=%h pen=%0d expected done %b err %b rdata %h pen %0d", n, got, stable, done_o, err_o, rdata_o, pen, 4'(1 << exp), hang, exp_rd, hang ? 16 : waits + 1);
            end
            mptr = exp;
            pending[exp] = 1'b0;
            req_i = pending;
        end
        slave_hang = 0;
        req_i = '0;
        tick(); tick();
        vectors++;
        if ({gnt_o, done_o, psel_o, penable_o} !== '0) begin
            miscompares++;
            $display("FAIL rand_final_idle: gnt=%b done=%b psel=%b expected 0", gnt_o, done_o, psel_o);
        end
    endtask

    initial begin
        preset   = 1'b1;
        req_i    = '0;
        addr_i   = '0;
        write_i  = '0;
        wdata_i  = '0;
        prdata_i = '0;
        pready_i = 1'b0;
        test_reset();
        test_single_read();
        test_write_wait();
        test_all_four();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_apb_rr_arbiter
`default_nettype wire
